// File: rtl/motor_ramp.sv
// ---------------------------------------------------------------------------
// motor_ramp
//
// Duty/direction slew limiter for one wheel. It sits between the software
// register block and the PWM generator / direction selector. Duty moves toward
// the software target by at most STEP per ramp tick. A direction reversal goes
// through four stages so that the H-bridge never sees an instant reversal under
// load: ramp down to 0, hold a dead time, switch direction, then ramp up.
// A disable takes effect at once and is not ramped.
//
// Parameters
//   TICK_DIV    clock cycles per ramp tick (>= 2)
//   STEP        duty change per tick (1..255)
//   DEAD_TICKS  ticks held at duty 0 before a direction switch (>= 1)
//
// Ports
//   clk        fabric clock
//   rst        synchronous, active-high reset
//   duty_in    target duty from the register block
//   dir_in     target direction from the register block
//   en_in      target enable from the register block
//   duty_out   applied duty, to the PWM generator (registered)
//   dir_out    applied direction, to the direction selector (registered)
//   en_out     applied enable, to the direction selector / EN pin (registered)
//   at_target  en_out=1 with duty_out=duty_in and dir_out=dir_in
// ---------------------------------------------------------------------------
module motor_ramp #(
    parameter int TICK_DIV   = 5000,
    parameter int STEP       = 4,
    parameter int DEAD_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] duty_in,
    input  logic       dir_in,
    input  logic       en_in,
    output logic [7:0] duty_out,
    output logic       dir_out,
    output logic       en_out,
    output logic       at_target
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEAD_TICKS + 1);

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TICKS);
    localparam logic [7:0]    STEP8     = 8'(STEP);
    localparam logic [8:0]    STEP9     = 9'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        BRAKE,
        DEAD
    } state_t;

    state_t          state;
    logic [CW-1:0]   tick_cnt;
    logic [DW-1:0]   dead_cnt;
    logic            tick;
    logic [8:0]      up_diff;
    logic [8:0]      down_diff;
    logic [7:0]      ramp_duty;
    logic [7:0]      brake_duty;

    // The tick counter free-runs and ignores the FSM, so ramp timing stays on
    // a fixed grid no matter when transitions happen.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Next duty for a RAMP tick and a BRAKE tick. The differences use 9 bits so
    // the STEP comparison cannot wrap. Landing on the target exactly prevents
    // overshoot when the remaining distance is smaller than STEP.
    always_comb begin
        up_diff    = {1'b0, duty_in} - {1'b0, duty_out};
        down_diff  = {1'b0, duty_out} - {1'b0, duty_in};
        ramp_duty  = duty_out;
        brake_duty = 8'd0;
        if (duty_in >= duty_out) begin
            ramp_duty = (up_diff <= STEP9) ? duty_in : duty_out + STEP8;
        end else begin
            ramp_duty = (down_diff <= STEP9) ? duty_in : duty_out - STEP8;
        end
        if ({1'b0, duty_out} > STEP9) begin
            brake_duty = duty_out - STEP8;
        end
    end

    // Main FSM. A low en_in overrides every state, including a tick in the
    // same cycle. While braking or in dead time, a direction request that
    // matches dir_out again cancels the reversal and goes back to RAMP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            duty_out <= 8'd0;
            dir_out  <= 1'b0;
            en_out   <= 1'b0;
            dead_cnt <= '0;
        end else if (!en_in) begin
            state    <= IDLE;
            duty_out <= 8'd0;
            en_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dir_out <= dir_in;
                    en_out  <= 1'b1;
                    state   <= RAMP;
                end
                RAMP: begin
                    if (dir_in != dir_out) begin
                        state <= BRAKE;
                    end else if (tick) begin
                        duty_out <= ramp_duty;
                    end
                end
                BRAKE: begin
                    if (dir_in == dir_out) begin
                        state <= RAMP;
                    end else if (duty_out == 8'd0) begin
                        state    <= DEAD;
                        dead_cnt <= DEAD_LOAD;
                    end else if (tick) begin
                        duty_out <= brake_duty;
                    end
                end
                DEAD: begin
                    if (dir_in == dir_out) begin
                        state <= RAMP;
                    end else if (dead_cnt == '0) begin
                        dir_out <= dir_in;
                        state   <= RAMP;
                    end else if (tick) begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    duty_out <= 8'd0;
                    en_out   <= 1'b0;
                end
            endcase
        end
    end

    assign at_target = en_out && (duty_out == duty_in) && (dir_out == dir_in);

endmodule

// File: tb/tb_motor_ramp.sv
// ---------------------------------------------------------------------------
// tb_motor_ramp
//
// Directed bench for motor_ramp with TICK_DIV=4, STEP=16, DEAD_TICKS=2.
// Inputs change 1 time unit after a rising edge and outputs are sampled at the
// same point. The bench tracks the tick phase itself: the tick counter is 0
// after the last reset edge, so a duty update lands on every fourth edge after
// that.
// ---------------------------------------------------------------------------
module tb_motor_ramp;

    localparam int TICK_DIV   = 4;
    localparam int STEP       = 16;
    localparam int DEAD_TICKS = 2;

    logic       clk;
    logic       rst;
    logic [7:0] duty_in;
    logic       dir_in;
    logic       en_in;
    logic [7:0] duty_out;
    logic       dir_out;
    logic       en_out;
    logic       at_target;

    int tests_run;
    int tests_failed;
    int phase;
    int model_duty;

    motor_ramp #(
        .TICK_DIV  (TICK_DIV),
        .STEP      (STEP),
        .DEAD_TICKS(DEAD_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .duty_in  (duty_in),
        .dir_in   (dir_in),
        .en_in    (en_in),
        .duty_out (duty_out),
        .dir_out  (dir_out),
        .en_out   (en_out),
        .at_target(at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int duty, input bit dir, input bit en);
        duty_in = 8'(duty);
        dir_in  = dir;
        en_in   = en;
    endtask

    // One rising edge, then settle; the phase tracks the DUT tick counter.
    task automatic step();
        @(posedge clk);
        #1;
        phase = (phase + 1) % TICK_DIV;
    endtask

    task automatic check_state(input string tag, input int exp_duty, input bit exp_dir, input bit exp_en);
        check_output({tag, " duty_out"}, int'(duty_out), exp_duty);
        check_output({tag, " dir_out"}, int'(dir_out), int'(exp_dir));
        check_output({tag, " en_out"}, int'(en_out), int'(exp_en));
        model_duty = exp_duty;
    endtask

    // Advance to the next tick edge. Just before it, the duty must still hold
    // its previous value, so updates are exactly one tick apart.
    task automatic next_tick(input string tag, input int exp_duty, input bit exp_dir);
        do begin
            if (phase == TICK_DIV - 1) begin
                check_output({tag, " hold before tick"}, int'(duty_out), model_duty);
            end
            step();
        end while (phase != 0);
        check_state(tag, exp_duty, exp_dir, 1'b1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        phase        = 0;
        model_duty   = 0;

        // Reset held 3 cycles with an active enable request.
        rst = 1'b1;
        apply_stimulus(200, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_state("reset", 0, 1'b0, 1'b0);
            check_output("reset at_target", int'(at_target), 0);
        end
        phase = 0;
        rst   = 1'b0;
        #1;
        check_state("after release", 0, 1'b0, 1'b0);
        step();
        check_state("enable latency", 0, 1'b0, 1'b1);

        // Ramp up to 64.
        apply_stimulus(64, 1'b0, 1'b1);
        next_tick("ramp 16", 16, 1'b0);
        check_output("ramp 16 at_target", int'(at_target), 0);
        next_tick("ramp 32", 32, 1'b0);
        next_tick("ramp 48", 48, 1'b0);
        next_tick("ramp 64", 64, 1'b0);
        check_output("ramp 64 at_target", int'(at_target), 1);
        next_tick("ramp settled", 64, 1'b0);

        // Remaining distance below STEP lands exactly on the target.
        apply_stimulus(70, 1'b0, 1'b1);
        next_tick("sat up 70", 70, 1'b0);
        apply_stimulus(5, 1'b0, 1'b1);
        next_tick("down 54", 54, 1'b0);
        next_tick("down 38", 38, 1'b0);
        next_tick("down 22", 22, 1'b0);
        next_tick("down 6", 6, 1'b0);
        next_tick("down 5", 5, 1'b0);
        check_output("down 5 at_target", int'(at_target), 1);

        // Back up to 64 from 5.
        apply_stimulus(64, 1'b0, 1'b1);
        next_tick("up 21", 21, 1'b0);
        next_tick("up 37", 37, 1'b0);
        next_tick("up 53", 53, 1'b0);
        next_tick("up 64", 64, 1'b0);

        // Reversal request, then withdrawn during dead time.
        apply_stimulus(64, 1'b1, 1'b1);
        next_tick("abort brake 48", 48, 1'b0);
        check_output("abort brake at_target", int'(at_target), 0);
        next_tick("abort brake 32", 32, 1'b0);
        next_tick("abort brake 16", 16, 1'b0);
        next_tick("abort brake 0", 0, 1'b0);
        next_tick("abort dead 1", 0, 1'b0);
        apply_stimulus(64, 1'b0, 1'b1);
        step();
        step();
        check_state("abort dir kept", 0, 1'b0, 1'b1);
        next_tick("abort ramp 16", 16, 1'b0);
        next_tick("abort ramp 32", 32, 1'b0);
        next_tick("abort ramp 48", 48, 1'b0);
        next_tick("abort ramp 64", 64, 1'b0);

        // Full reversal: ramp down, 2 dead ticks, switch, ramp up.
        apply_stimulus(64, 1'b1, 1'b1);
        next_tick("rev brake 48", 48, 1'b0);
        next_tick("rev brake 32", 32, 1'b0);
        next_tick("rev brake 16", 16, 1'b0);
        next_tick("rev brake 0", 0, 1'b0);
        next_tick("rev dead 1", 0, 1'b0);
        next_tick("rev dead 2", 0, 1'b0);
        step();
        check_state("rev switch", 0, 1'b1, 1'b1);
        next_tick("rev ramp 16", 16, 1'b1);
        next_tick("rev ramp 32", 32, 1'b1);
        next_tick("rev ramp 48", 48, 1'b1);
        next_tick("rev ramp 64", 64, 1'b1);
        check_output("rev at_target", int'(at_target), 1);

        // Disable is immediate; re-enable ramps from 0.
        apply_stimulus(64, 1'b1, 1'b0);
        step();
        check_state("disable at 64", 0, 1'b1, 1'b0);
        check_output("disable at_target", int'(at_target), 0);
        apply_stimulus(64, 1'b1, 1'b1);
        step();
        check_state("re-enable", 0, 1'b1, 1'b1);
        next_tick("re-ramp 16", 16, 1'b1);
        next_tick("re-ramp 32", 32, 1'b1);

        // Disable on the same edge as a tick: the disable wins.
        while (phase != TICK_DIV - 1) begin
            step();
        end
        check_output("pre-disable duty", int'(duty_out), 32);
        apply_stimulus(64, 1'b1, 1'b0);
        step();
        check_state("disable on tick", 0, 1'b1, 1'b0);
        apply_stimulus(64, 1'b1, 1'b1);
        step();
        check_state("re-enable 2", 0, 1'b1, 1'b1);
        next_tick("restart 16", 16, 1'b1);

        // Reset mid-ramp clears everything on the next edge.
        rst = 1'b1;
        step();
        check_state("mid reset", 0, 1'b0, 1'b0);
        check_output("mid reset at_target", int'(at_target), 0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
